// File: rtl/bus_copy_master_pkg.sv
// Shared types and constants for the bus copy/fill master.
package bus_copy_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_FIN
  } state_e;

  localparam logic [3:0]  BE_FULL    = 4'hF;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/bus_copy_master.sv
// Bus initiator that copies a block of words (read/capture/write per word)
// or fills a range with a constant pattern (one write per cycle).
module bus_copy_master
  import bus_copy_master_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_start,
  input  logic             cmd_fill,
  input  logic [31:0]      cmd_src,
  input  logic [31:0]      cmd_dst,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      cmd_pattern,
  input  logic             cmd_abort,
  output logic             busy,
  output logic             done,
  output logic             bus_req,
  output logic             bus_we,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  output logic [3:0]       bus_be,
  input  logic [31:0]      bus_rdata
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             fill_q, fill_d;
  logic [31:0]      pat_q, pat_d;
  logic [31:0]      data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  assign busy      = busy_q;
  assign done      = done_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = BE_FULL;

  // Next-state, datapath updates and registered-output decode.
  // Bus outputs are derived from the next state so they are valid in the
  // same cycle the FSM occupies RD/WR, keeping read data aligned with CAP.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          src_d  = cmd_src & ~32'd3;
          dst_d  = cmd_dst & ~32'd3;
          rem_d  = cmd_len;
          fill_d = cmd_fill;
          pat_d  = cmd_pattern;
          if (cmd_len == '0)  state_d = ST_FIN;
          else if (cmd_fill)  state_d = ST_WR;
          else                state_d = ST_RD;
        end
      end
      ST_RD: begin
        state_d = cmd_abort ? ST_FIN : ST_CAP;
      end
      ST_CAP: begin
        if (cmd_abort) begin
          state_d = ST_FIN;
        end else begin
          data_d  = bus_rdata;
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        dst_d = dst_q + WORD_BYTES;
        src_d = src_q + WORD_BYTES;
        rem_d = rem_q - LEN_ONE;
        if (cmd_abort || rem_q == LEN_ONE) state_d = ST_FIN;
        else if (fill_q)                   state_d = ST_WR;
        else                               state_d = ST_RD;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_d   = (state_d == ST_RD) || (state_d == ST_WR);
    we_d    = (state_d == ST_WR);
    busy_d  = (state_d == ST_RD) || (state_d == ST_CAP) || (state_d == ST_WR);
    done_d  = (state_d == ST_FIN);
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_d == ST_RD) begin
      addr_d = src_d;
    end else if (state_d == ST_WR) begin
      addr_d  = dst_d;
      wdata_d = fill_d ? pat_d : data_d;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      pat_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_bus_copy_master.sv
// Self-checking bench for bus_copy_master: bus-slave memory, per-cycle
// expectation queue built from the transfer rules, directed and random tests.
module tb_bus_copy_master;

  localparam int unsigned LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             cmd_start = 1'b0;
  logic             cmd_fill = 1'b0;
  logic [31:0]      cmd_src = '0;
  logic [31:0]      cmd_dst = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [31:0]      cmd_pattern = '0;
  logic             cmd_abort = 1'b0;
  logic             busy, done, bus_req, bus_we;
  logic [31:0]      bus_addr, bus_wdata;
  logic [3:0]       bus_be;
  logic [31:0]      bus_rdata = '0;

  bus_copy_master #(.LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_start(cmd_start), .cmd_fill(cmd_fill), .cmd_src(cmd_src),
    .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
    .cmd_abort(cmd_abort), .busy(busy), .done(done),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_rdata(bus_rdata)
  );

  always #5 clk_i = ~clk_i;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave memory
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  always @(posedge clk_i) begin
    if (bus_req && bus_we) mem[bus_addr] = bus_wdata;
    if (bus_req && !bus_we) bus_rdata <= rd_mem(bus_addr);
    else                    bus_rdata <= $urandom;
  end

  // Per-cycle expectation queue
  typedef struct {
    bit          req;
    bit          we;
    bit          busy;
    bit          done;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cyc_t;

  cyc_t exp_q[$];
  bit   chk_en = 1'b0;

  task automatic push(input bit req, input bit we, input bit bsy, input bit dn,
                      input logic [31:0] a, input logic [31:0] d);
    cyc_t c;
    c.req = req; c.we = we; c.busy = bsy; c.done = dn; c.addr = a; c.wdata = d;
    exp_q.push_back(c);
  endtask

  // Compare process: idle is expected whenever the queue is empty
  always @(negedge clk_i) begin
    if (chk_en) begin
      cyc_t e;
      e = '{default: '0};
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk("bus_req", {31'd0, bus_req}, {31'd0, e.req});
      chk("bus_we",  {31'd0, bus_we},  {31'd0, e.we});
      chk("busy",    {31'd0, busy},    {31'd0, e.busy});
      chk("done",    {31'd0, done},    {31'd0, e.done});
      if (e.req) chk("bus_addr", bus_addr, e.addr);
      if (e.we)  chk("bus_wdata", bus_wdata, e.wdata);
      if (bus_req) chk("bus_be", {28'd0, bus_be}, 32'hF);
    end
  end

  // Activity counters, independent of the expectation queue
  int unsigned n_wr = 0, n_rd = 0, n_done = 0, n_busy = 0;
  always @(negedge clk_i) begin
    if (bus_req && bus_we)  n_wr++;
    if (bus_req && !bus_we) n_rd++;
    if (done)               n_done++;
    if (busy)               n_busy++;
  end

  task automatic clr_cnt();
    n_wr = 0; n_rd = 0; n_done = 0; n_busy = 0;
  endtask

  // Issue one command, build its expected timeline, optionally abort at
  // word aw / phase ph (0 read, 1 capture, 2 write), poke a start while busy,
  // or raise abort together with the start.
  task automatic run_cmd(input bit fill, input logic [31:0] src, input logic [31:0] dst,
                         input int unsigned len, input logic [31:0] pat,
                         input int aw, input int ph, input bit poke, input bit abort_with_start);
    logic [31:0] s, d, sa, da;
    int unsigned off, budget;
    s = src & ~32'd3;
    d = dst & ~32'd3;
    @(posedge clk_i); #1;
    push(0, 0, 0, 0, '0, '0);
    for (int i = 0; i < int'(len); i++) begin
      sa = s + 32'(i) * 32'd4;
      da = d + 32'(i) * 32'd4;
      if (fill) begin
        push(1, 1, 1, 0, da, pat);
        if (i == aw) break;
      end else begin
        push(1, 0, 1, 0, sa, '0);
        if (i == aw && ph == 0) break;
        push(0, 0, 1, 0, '0, '0);
        if (i == aw && ph == 1) break;
        push(1, 1, 1, 0, da, rd_mem(sa));
        if (i == aw) break;
      end
    end
    push(0, 0, 0, 1, '0, '0);

    cmd_fill = fill; cmd_src = src; cmd_dst = dst; cmd_len = LEN_W'(len);
    cmd_pattern = pat; cmd_start = 1'b1; cmd_abort = abort_with_start;
    @(posedge clk_i); #1;
    cmd_start = 1'b0; cmd_abort = 1'b0;
    if (aw >= 0) begin
      off = fill ? 32'(1 + aw) : 32'(1 + 3 * aw + ph);
      repeat (off - 1) begin @(posedge clk_i); #1; end
      cmd_abort = 1'b1;
      @(posedge clk_i); #1;
      cmd_abort = 1'b0;
    end else if (poke) begin
      cmd_start = 1'b1; cmd_fill = ~fill; cmd_len = LEN_W'(5);
      cmd_src = 32'h0000_7700; cmd_dst = 32'h0000_7800; cmd_pattern = 32'h5555_AAAA;
      @(posedge clk_i); #1;
      cmd_start = 1'b0;
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(posedge clk_i);
      budget++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [31:0] src_r, dst_r, pat_r;
    int unsigned len_r;
    int aw_r, ph_r;
    bit fill_r, poke_r;

    // Reset state
    #12;
    chk("rst_req",   {31'd0, bus_req}, 32'd0);
    chk("rst_we",    {31'd0, bus_we},  32'd0);
    chk("rst_busy",  {31'd0, busy},    32'd0);
    chk("rst_done",  {31'd0, done},    32'd0);
    chk("rst_addr",  bus_addr,  32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_be",    {28'd0, bus_be}, 32'hF);
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk_en = 1'b1;

    // Copy of four words
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(i) * 4] = 32'hA0A0_0000 + 32'(i);
    clr_cnt();
    run_cmd(1'b0, 32'h100, 32'h200, 4, 32'h0, -1, 0, 1'b0, 1'b0);
    chk("copy_busy_cycles", n_busy, 32'd12);
    chk("copy_writes", n_wr, 32'd4);
    chk("copy_reads", n_rd, 32'd4);
    chk("copy_done", n_done, 32'd1);
    for (int i = 0; i < 4; i++) chk("copy_mem", rd_mem(32'h200 + 32'(i) * 4), 32'hA0A0_0000 + 32'(i));

    // Fill of eight words
    clr_cnt();
    run_cmd(1'b1, 32'h0, 32'h40, 8, 32'hDEAD_BEEF, -1, 0, 1'b0, 1'b0);
    chk("fill_writes", n_wr, 32'd8);
    chk("fill_busy_cycles", n_busy, 32'd8);
    chk("fill_first", rd_mem(32'h40), 32'hDEAD_BEEF);
    chk("fill_last", rd_mem(32'h5C), 32'hDEAD_BEEF);

    // Zero length
    clr_cnt();
    run_cmd(1'b0, 32'h100, 32'h300, 0, 32'h0, -1, 0, 1'b0, 1'b0);
    chk("zero_reqs", n_wr + n_rd, 32'd0);
    chk("zero_done", n_done, 32'd1);
    chk("zero_busy", n_busy, 32'd0);

    // Abort in the capture of word 2 of a 10-word copy
    for (int i = 0; i < 10; i++) begin
      mem[32'h600 + 32'(i) * 4] = 32'hC0DE_0000 + 32'(i);
      mem[32'h700 + 32'(i) * 4] = 32'h0BAD_0BAD;
    end
    clr_cnt();
    run_cmd(1'b0, 32'h600, 32'h700, 10, 32'h0, 1, 1, 1'b0, 1'b0);
    chk("abort_writes", n_wr, 32'd1);
    chk("abort_done", n_done, 32'd1);
    chk("abort_word0", rd_mem(32'h700), 32'hC0DE_0000);
    chk("abort_word1", rd_mem(32'h704), 32'h0BAD_0BAD);

    // Address wrap in fill mode
    run_cmd(1'b1, 32'h0, 32'hFFFF_FFF8, 3, 32'h1234_5678, -1, 0, 1'b0, 1'b0);
    chk("wrap_fff8", rd_mem(32'hFFFF_FFF8), 32'h1234_5678);
    chk("wrap_fffc", rd_mem(32'hFFFF_FFFC), 32'h1234_5678);
    chk("wrap_0",    rd_mem(32'h0),         32'h1234_5678);

    // Abort alone in idle is ignored; start+abort together starts normally
    cmd_abort = 1'b1;
    @(posedge clk_i); #1;
    cmd_abort = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    clr_cnt();
    run_cmd(1'b1, 32'h0, 32'h900, 2, 32'h0F0F_0F0F, -1, 0, 1'b0, 1'b1);
    chk("start_abort_writes", n_wr, 32'd2);

    // Start while busy leaves the running command untouched
    clr_cnt();
    run_cmd(1'b0, 32'h600, 32'hA00, 3, 32'h0, -1, 0, 1'b1, 1'b0);
    chk("poke_writes", n_wr, 32'd3);
    chk("poke_mem", rd_mem(32'hA08), 32'hC0DE_0002);

    // Asynchronous reset during the write of word 2
    for (int i = 0; i < 4; i++) mem[32'h300 + 32'(i) * 4] = 32'h3300_0000 + 32'(i);
    chk_en = 1'b0;
    clr_cnt();
    @(posedge clk_i); #1;
    cmd_fill = 1'b0; cmd_src = 32'h300; cmd_dst = 32'h400; cmd_len = LEN_W'(4);
    cmd_start = 1'b1;
    @(posedge clk_i); #1;
    cmd_start = 1'b0;
    repeat (5) begin @(posedge clk_i); #1; end
    chk("rst_mid_wr", {30'd0, bus_req, bus_we}, 32'd3);
    chk("rst_mid_addr", bus_addr, 32'h404);
    #1 rst_i = 1'b0;
    #1;
    chk("arst_req",   {31'd0, bus_req}, 32'd0);
    chk("arst_we",    {31'd0, bus_we},  32'd0);
    chk("arst_busy",  {31'd0, busy},    32'd0);
    chk("arst_addr",  bus_addr,  32'd0);
    chk("arst_wdata", bus_wdata, 32'd0);
    chk("arst_be",    {28'd0, bus_be}, 32'hF);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); rst_i = 1'b1;
    chk_en = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    chk("arst_no_done", n_done, 32'd0);
    chk("arst_word0_kept", rd_mem(32'h400), 32'h3300_0000);
    clr_cnt();
    run_cmd(1'b0, 32'h300, 32'h400, 4, 32'h0, -1, 0, 1'b0, 1'b0);
    chk("after_rst_writes", n_wr, 32'd4);
    chk("after_rst_mem", rd_mem(32'h40C), 32'h3300_0003);

    // Randomized commands against the expectation timeline
    for (int it = 0; it < 14; it++) begin
      fill_r = 1'($urandom_range(0, 1));
      len_r  = $urandom_range(0, 6);
      src_r  = 32'h1000 + 32'(it) * 32'h100 + 32'($urandom_range(0, 3));
      dst_r  = 32'h8000 + 32'(it) * 32'h100 + 32'($urandom_range(0, 3));
      pat_r  = $urandom;
      for (int i = 0; i < 8; i++) mem[(src_r & ~32'd3) + 32'(i) * 4] = $urandom;
      aw_r = -1; ph_r = 0; poke_r = 1'b0;
      if (len_r > 0 && $urandom_range(0, 3) == 0) begin
        aw_r = int'($urandom_range(0, len_r - 1));
        ph_r = fill_r ? 2 : int'($urandom_range(0, 2));
      end else if (len_r > 0) begin
        poke_r = 1'($urandom_range(0, 1));
      end
      run_cmd(fill_r, src_r, dst_r, len_r, pat_r, aw_r, ph_r, poke_r, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
